// File: rtl/uart_pkg.sv
// Shared definitions for the UART message front end: bit-FSM state encoding
// and the default link/message geometry used by the encoder top.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  localparam int DEF_CLKS_PER_BIT = 1042;
  localparam int DEF_MSG_BYTES    = 11;
  localparam int DEF_TIMEOUT_BITS = 40;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-FF synchronizer, bit FSM with mid-bit sampling, and a
// byte strobe raised combinationally in the cycle of an accepted stop sample.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  byte_data,
  output logic        byte_strobe,
  output logic        frame_err,
  output logic        start_edge,
  output logic        line_idle,
  output uart_state_e state
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta_q;
  logic             rxs_q;
  logic             rxs_prev_q;
  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             frame_err_q, frame_err_d;

  // Synchronizer and edge history idle high so reset never fakes a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    byte_strobe = 1'b0;
    start_edge  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs_q) begin
          start_edge = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        // Half-bit wait puts every later sample in the middle of its bit.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxs_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            byte_strobe = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign byte_data = shreg_q;
  assign frame_err = frame_err_q;
  assign line_idle = (state_q == ST_IDLE);
  assign state     = state_q;

endmodule

// File: rtl/uart_msg_receiver.sv
// Assembles accepted UART bytes into a fixed-length message and hands it to
// the encoder core; discards stale partial messages after an idle timeout.
module uart_msg_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int MSG_BYTES    = DEF_MSG_BYTES,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  input  logic                   msg_ack,
  output logic [8*MSG_BYTES-1:0] msg_data,
  output logic                   msg_valid,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   timeout,
  output uart_state_e            dbg_state,
  output logic [7:0]             dbg_wr_idx
);

  localparam int IDX_W   = cnt_width(MSG_BYTES);
  localparam int TO_TERM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W    = cnt_width(TO_TERM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_TERM - 1);

  logic [7:0] byte_data;
  logic       byte_strobe;
  logic       start_edge;
  logic       line_idle;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_strobe(byte_strobe),
    .frame_err  (frame_err),
    .start_edge (start_edge),
    .line_idle  (line_idle),
    .state      (dbg_state)
  );

  logic [8*MSG_BYTES-1:0] msg_data_q, msg_data_d;
  logic                   msg_valid_q, msg_valid_d;
  logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;
  logic                   valid_eff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_data_q  <= '0;
      msg_valid_q <= 1'b0;
      wr_idx_q    <= '0;
      to_cnt_q    <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      msg_data_q  <= msg_data_d;
      msg_valid_q <= msg_valid_d;
      wr_idx_q    <= wr_idx_d;
      to_cnt_q    <= to_cnt_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  // Handshake: msg_valid is a level that holds msg_data stable until the
  // encoder pulses msg_ack while msg_valid is high; valid drops the next
  // cycle. An ack in the same cycle as a stop sample frees the buffer first,
  // so that byte lands at index 0 instead of being reported as an overrun.
  assign valid_eff = msg_valid_q && !msg_ack;

  always_comb begin
    msg_data_d  = msg_data_q;
    msg_valid_d = msg_valid_q;
    wr_idx_d    = wr_idx_q;
    to_cnt_d    = to_cnt_q;
    overrun_d   = 1'b0;
    timeout_d   = 1'b0;
    if (msg_valid_q && msg_ack) msg_valid_d = 1'b0;
    if (byte_strobe) begin
      to_cnt_d = '0;
      if (valid_eff) begin
        overrun_d = 1'b1;
      end else begin
        for (int i = 0; i < MSG_BYTES; i++) begin
          if (wr_idx_q == IDX_W'(i)) msg_data_d[8*i +: 8] = byte_data;
        end
        if (wr_idx_q == LAST_IDX) begin
          wr_idx_d    = '0;
          msg_valid_d = 1'b1;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end
    end else if (wr_idx_q != '0 && line_idle) begin
      // A start edge on the terminal cycle keeps the partial message.
      if (start_edge) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        to_cnt_d  = '0;
        wr_idx_d  = '0;
        timeout_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  assign msg_data   = msg_data_q;
  assign msg_valid  = msg_valid_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;
  assign dbg_wr_idx = 8'(wr_idx_q);

endmodule

// File: tb/tb_uart_msg_receiver.sv
// Bench for uart_msg_receiver: random byte traffic checked against a queue
// model of message assembly, plus glitch, framing, overrun, timeout and reset cases.
module tb_uart_msg_receiver;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int MB  = 4;
  localparam int TOB = 8;
  localparam int W   = 8 * MB;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            rx = 1'b1;
  logic            msg_ack = 1'b0;
  logic [W-1:0]    msg_data;
  logic            msg_valid, frame_err, overrun, timeout;
  uart_state_e     dbg_state;
  logic [7:0]      dbg_wr_idx;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0, ov_cnt = 0, to_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   mdl_bytes[$];
  bit           mdl_valid = 1'b0;
  logic [W-1:0] cur_msg = '0;

  always #5 clk = ~clk;

  uart_msg_receiver #(
    .CLKS_PER_BIT(CPB),
    .MSG_BYTES   (MB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .msg_ack   (msg_ack),
    .msg_data  (msg_data),
    .msg_valid (msg_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .timeout   (timeout),
    .dbg_state (dbg_state),
    .dbg_wr_idx(dbg_wr_idx)
  );

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (timeout) to_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_accept(input logic [7:0] b, output bit exp_ov);
    logic [W-1:0] w;
    exp_ov = mdl_valid;
    if (!mdl_valid) begin
      mdl_bytes.push_back(b);
      if (mdl_bytes.size() == MB) begin
        w = '0;
        for (int i = 0; i < MB; i++) w = w + (W'(mdl_bytes[i]) << (8 * i));
        exp_q.push_back(w);
        mdl_bytes.delete();
        mdl_valid = 1'b1;
      end
    end
  endtask

  task automatic model_ack();
    mdl_valid = 1'b0;
  endtask

  task automatic model_clear_partial();
    mdl_bytes.delete();
  endtask

  // ---------------- drivers ----------------
  // Starts at a negedge; obs = {overrun, frame_err, msg_valid} at negedges 154/155.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int gap,
                            input bit ack_at_stop, input int abort_at,
                            output logic [2:0] obs154, output logic [2:0] obs155);
    obs154 = '0;
    obs155 = '0;
    rx = 1'b0;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      if (k == 154) obs154 = {overrun, frame_err, msg_valid};
      if (k == 155) obs155 = {overrun, frame_err, msg_valid};
      if (k == abort_at) begin
        reset = 1'b0;
        rx = 1'b1;
        return;
      end
      if (k % 16 == 0 && k <= 128) rx = b[k/16 - 1];
      if (k == 144) rx = stop_bit;
      if (ack_at_stop) msg_ack = (k == 154);
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_ack();
    msg_ack = 1'b1;
    @(negedge clk);
    msg_ack = 1'b0;
    model_ack();
  endtask

  // Sends n random bytes; the last one completes a message which is checked.
  task automatic send_random_completion(input int n, input string tag);
    logic [7:0] b;
    logic [2:0] o154, o155;
    bit eov;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, $urandom_range(1, 4), 1'b0, 0, o154, o155);
      model_accept(b, eov);
    end
    checks++;
    if (o155[0] !== 1'b1 || o154[0] !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid_latency: valid@154=%b valid@155=%b, need 0 then 1", tag, o154[0], o155[0]);
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_model: no expected message queued", tag);
    end else begin
      cur_msg = exp_q.pop_front();
      checks++;
      if (msg_data !== cur_msg) begin
        errors++;
        $display("FAIL %s_data: got %h expected %h", tag, msg_data, cur_msg);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({msg_valid, frame_err, overrun, timeout} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {msg_valid, frame_err, overrun, timeout});
    end
    checks++;
    if (msg_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", msg_data);
    end
    checks++;
    if (dbg_state !== ST_IDLE || dbg_wr_idx !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d idx=%0d expected IDLE/0", dbg_state, dbg_wr_idx);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_spec_message();
    logic [7:0] bytes [4];
    logic [2:0] o154, o155;
    bit eov;
    bytes = '{8'h57, 8'h31, 8'h41, 8'h42};
    for (int i = 0; i < 4; i++) begin
      send_frame(bytes[i], 1'b1, (i == 3) ? 2 : $urandom_range(1, 4), 1'b0, 0, o154, o155);
      model_accept(bytes[i], eov);
    end
    checks++;
    if (o154[0] !== 1'b0 || o155[0] !== 1'b1) begin
      errors++;
      $display("FAIL spec_valid_latency: valid@154=%b valid@155=%b, need 0 then 1", o154[0], o155[0]);
    end
    checks++;
    if (msg_data !== 32'h4241_3157) begin
      errors++;
      $display("FAIL spec_data: got %h expected 42413157", msg_data);
    end
    cur_msg = exp_q.pop_front();
    pulse_ack();
    checks++;
    if (msg_valid !== 1'b0) begin
      errors++;
      $display("FAIL spec_ack_clear: msg_valid=%b expected 0", msg_valid);
    end
  endtask

  task automatic test_random_messages(input int n);
    for (int m = 0; m < n; m++) begin
      send_random_completion(MB, "rand");
      repeat ($urandom_range(0, 5)) @(negedge clk);
      checks++;
      if (msg_valid !== 1'b1 || msg_data !== cur_msg) begin
        errors++;
        $display("FAIL rand_hold: valid=%b data=%h expected 1/%h", msg_valid, msg_data, cur_msg);
      end
      pulse_ack();
      checks++;
      if (msg_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_ack_clear: msg_valid=%b expected 0", msg_valid);
      end
    end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (fe_cnt !== fe0 || msg_valid !== 1'b0 || dbg_state !== ST_IDLE || dbg_wr_idx !== 8'd0) begin
      errors++;
      $display("FAIL glitch: fe_pulses=%0d valid=%b state=%0d idx=%0d expected 0/0/IDLE/0",
               fe_cnt - fe0, msg_valid, dbg_state, dbg_wr_idx);
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] b;
    logic [2:0] o154, o155;
    bit eov;
    int fe0;
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, 2, 1'b0, 0, o154, o155);
    model_accept(b, eov);
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 0, 1'b0, 0, o154, o155);
    checks++;
    if (o154[1] !== 1'b0 || o155[1] !== 1'b1) begin
      errors++;
      $display("FAIL ferr_latency: ferr@154=%b ferr@155=%b, need 0 then 1", o154[1], o155[1]);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (fe_cnt !== fe0 + 1 || dbg_state !== ST_BREAK || dbg_wr_idx !== 8'(mdl_bytes.size())) begin
      errors++;
      $display("FAIL ferr_break: pulses=%0d state=%0d idx=%0d expected 1/BREAK/%0d",
               fe_cnt - fe0, dbg_state, dbg_wr_idx, mdl_bytes.size());
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    send_random_completion(MB - 1, "ferr_recover");
    pulse_ack();
  endtask

  task automatic test_overrun();
    logic [2:0] o154, o155;
    bit eov;
    int ov0;
    send_random_completion(MB, "ovr_fill");
    ov0 = ov_cnt;
    send_frame(8'hAA, 1'b1, 3, 1'b0, 0, o154, o155);
    model_accept(8'hAA, eov);
    checks++;
    if (o154[2] !== 1'b0 || o155[2] !== eov || ov_cnt !== ov0 + 1) begin
      errors++;
      $display("FAIL overrun_pulse: ovr@154=%b ovr@155=%b pulses=%0d expected 0/%b/1",
               o154[2], o155[2], ov_cnt - ov0, eov);
    end
    checks++;
    if (msg_valid !== 1'b1 || msg_data !== cur_msg) begin
      errors++;
      $display("FAIL overrun_data: valid=%b data=%h expected 1/%h", msg_valid, msg_data, cur_msg);
    end
    pulse_ack();
  endtask

  task automatic test_ack_collision();
    logic [7:0] b;
    logic [2:0] o154, o155;
    bit eov;
    send_random_completion(MB, "coll_fill");
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, 2, 1'b1, 0, o154, o155);
    model_ack();
    model_accept(b, eov);
    checks++;
    if (o155[2] !== eov || o155[0] !== 1'b0 || dbg_wr_idx !== 8'(mdl_bytes.size())) begin
      errors++;
      $display("FAIL ack_collision: ovr=%b valid=%b idx=%0d expected %b/0/%0d",
               o155[2], o155[0], dbg_wr_idx, eov, mdl_bytes.size());
    end
    send_random_completion(MB - 1, "coll_next");
    pulse_ack();
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    logic [2:0] o154, o155;
    bit eov;
    int to0;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, (i == 1) ? 0 : 2, 1'b0, 0, o154, o155);
      model_accept(b, eov);
    end
    to0 = to_cnt;
    for (int k = 1; k <= 124; k++) begin
      @(negedge clk);
      if (k == 121) begin
        checks++;
        if (to_cnt !== to0) begin
          errors++;
          $display("FAIL timeout_early: %0d pulses before terminal count, expected 0", to_cnt - to0);
        end
      end
      if (k == 122 || k == 123) begin
        checks++;
        if (timeout !== (k == 123)) begin
          errors++;
          $display("FAIL timeout_edge_%0d: timeout=%b expected %b", k, timeout, (k == 123));
        end
      end
    end
    model_clear_partial();
    checks++;
    if (dbg_wr_idx !== 8'd0 || to_cnt !== to0 + 1) begin
      errors++;
      $display("FAIL timeout_discard: idx=%0d pulses=%0d expected 0/1", dbg_wr_idx, to_cnt - to0);
    end
    send_random_completion(MB, "to_after");
    pulse_ack();
  endtask

  task automatic test_timeout_race();
    logic [7:0] b;
    logic [2:0] o154, o155;
    bit eov;
    int to0;
    to0 = to_cnt;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, (i == 1) ? 0 : 2, 1'b0, 0, o154, o155);
      model_accept(b, eov);
    end
    repeat (120) @(negedge clk);
    send_random_completion(MB - 2, "race");
    checks++;
    if (to_cnt !== to0) begin
      errors++;
      $display("FAIL race_no_timeout: %0d timeout pulses, expected 0", to_cnt - to0);
    end
    pulse_ack();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    logic [2:0] o154, o155;
    bit eov;
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, 2, 1'b0, 0, o154, o155);
    model_accept(b, eov);
    send_frame(8'($urandom_range(0, 255)), 1'b1, 0, 1'b0, 70, o154, o155);
    @(negedge clk);
    exp_q.delete();
    mdl_bytes.delete();
    mdl_valid = 1'b0;
    checks++;
    if ({msg_valid, frame_err, overrun, timeout} !== 4'b0 || msg_data !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: flags=%b data=%h expected 0000/0",
               {msg_valid, frame_err, overrun, timeout}, msg_data);
    end
    checks++;
    if (dbg_state !== ST_IDLE || dbg_wr_idx !== 8'd0) begin
      errors++;
      $display("FAIL midreset_state: state=%0d idx=%0d expected IDLE/0", dbg_state, dbg_wr_idx);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    send_random_completion(MB, "post_reset");
    pulse_ack();
  endtask

  initial begin
    test_reset();
    test_spec_message();
    test_random_messages(3);
    test_glitch();
    test_frame_err();
    test_overrun();
    test_ack_collision();
    test_timeout();
    test_timeout_race();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_msg_receiver.md
# uart_msg_receiver

Front-end stage of the WSPR encoder datapath: receives 8N1 UART bytes on the `rx` pin and assembles a fixed-length message buffer. It presents the buffer to the encoder core with a valid/ack handshake. The encoder only consumes the message when `msg_valid` is high; it acknowledges once it has latched the buffer, and the buffer can then be overwritten.

## Interface
- `CLKS_PER_BIT`, 1042: clock cycles per UART bit (10 MHz / 9600 Bd); minimum 4.
- `MSG_BYTES`, 11: bytes per message (callsign, locator, power).
- `TIMEOUT_BITS`, 40: idle bit-times after a stop bit before a partial message is discarded.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx` in 1: UART line, idle high, asynchronous to `clk`.
- `msg_ack` in 1: encoder has latched `msg_data`; single-cycle pulse.
- `msg_data` out 8*MSG_BYTES: assembled message; byte 0 (first received) in [7:0].
- `msg_valid` out 1: message complete and stable.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a byte is dropped because `msg_valid` is high.
- `timeout` out 1: one-cycle pulse when a partial message is discarded.

## Operation
- `rx` passes through a 2-FF synchronizer that resets to 1. All logic uses the synchronized signal `rxs`.
- Bit FSM states:
  - IDLE: a 1→0 transition on `rxs` → START.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. `rxs`=1 is a glitch → IDLE. `rxs`=0 → DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first → STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - `rxs`=1: byte accepted → IDLE.
    - `rxs`=0: `frame_err` pulse, byte discarded → BREAK.
  - BREAK: wait for `rxs`=1 → IDLE.
- Assembler, on an accepted byte:
  - `msg_valid`=0: store the byte at `wr_idx` and increment `wr_idx`. If `wr_idx` reaches MSG_BYTES, reset it to 0 and set `msg_valid`.
  - `msg_valid`=1: `overrun` pulse; the byte is dropped and `msg_data` is untouched.
- `msg_valid` is a level; it clears the cycle after `msg_ack`=1. `msg_ack` while `msg_valid`=0 is ignored.
- `msg_data` changes only while `msg_valid`=0.
- Timeout: with `wr_idx`≠0 and the FSM in IDLE, count clocks from the accepting stop sample. At TIMEOUT_BITS*CLKS_PER_BIT clocks: `wr_idx`←0 and `timeout` pulses. A start edge clears the count.
- `frame_err` does not reset `wr_idx`; the timeout covers recovery.

## Timing
- Reset values:
  - all outputs 0, `msg_data` 0.
  - FSM IDLE, `wr_idx` 0, counters 0.
  - synchronizer 1.
- Reset mid-frame aborts the byte and the partial message immediately.
- Sample point is mid-bit: the first data sample comes 1.5·CLKS_PER_BIT clocks after the synchronized falling edge.
- Accepted-byte latency: `msg_valid` rises exactly 1 clock after the final byte's stop sample; `msg_data` is valid in that same cycle.
- `frame_err`, `overrun` and `timeout` assert 1 clock after their triggering sample or count terminal.
- A stop sample and `msg_ack` in the same cycle: the ack is processed first, the byte is stored at index 0, and there is no overrun.
- Timeout terminal count and a start edge in the same cycle: the start wins and there is no timeout.
- Back-to-back frames are supported: a start edge is accepted on the first IDLE cycle after the stop sample.

## Structure
- Package `uart_pkg` holds:
  - the bit-FSM state enum (IDLE, START, DATA, STOP, BREAK).
  - the default CLKS_PER_BIT and MSG_BYTES constants, shared with the encoder top.
- Sub-module `uart_rx_core` contains the synchronizer, bit FSM and bit counters.
  - Outputs: `byte_data[7:0]`, `byte_strobe`, `frame_err`.
- `uart_msg_receiver` instantiates `uart_rx_core` and adds the assembler, handshake and timeout counter.

## Test plan
All scenarios use CLKS_PER_BIT=16, MSG_BYTES=4, TIMEOUT_BITS=8.
- Send 0x57 0x31 0x41 0x42 → `msg_valid`=1 with `msg_data`=0x42413157, 1 clk after the 4th stop sample. `msg_ack` → `msg_valid`=0 next clk.
- 6-clk low glitch on `rx` → no byte, no `frame_err`, FSM back in IDLE.
- Frame 0x55 with stop bit held low → `frame_err` pulse, `wr_idx` unchanged. The next frame is accepted only after `rx` returns high.
- Full message with no ack, then a 5th byte 0xAA → `overrun` pulse, `msg_data` unchanged.
- Send 2 bytes, then idle 128 clks → `timeout` pulse. A following 4-byte message assembles correctly from index 0.
- Assert `reset` during bit 3 of byte 2 → all outputs 0. A fresh 4-byte message after release completes normally.
